shift_tx_sched: RTL and testbench
=================================

SHIFT_TX_SCHED -- requirements
Module: shift_tx_sched

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the parallel word width, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, requester word offered.
REQ-005 The block SHALL have ports req0_data / req1_data, input, DATA_W each, requester parallel word.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1 each, word accepted this cycle when ANDed with the matching valid.
REQ-007 The block SHALL have port sdo, output, 1, serial data out, MSB first.
REQ-008 The block SHALL have port sdo_en, output, 1, high while sdo carries a frame bit.
REQ-009 The block SHALL have port frame_start, output, 1, high on the first bit of each frame only.
REQ-010 The block SHALL have port grant_id, output, 1, index of the requester whose frame is on sdo; valid while sdo_en=1.
REQ-011 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and PAR; PAR exists only when the Configuration macro is defined.
REQ-013 In IDLE with at least one valid, the block SHALL raise exactly one ready (combinational from state, valids and last_grant); in every other state both readies SHALL be 0.
REQ-014 Arbitration: a single requester SHALL be granted; with both valid, the block SHALL grant the requester not served last (round robin).
REQ-015 On the accept edge, the block SHALL load the word into an internal DATA_W shift register, record grant_id, set last_grant, load a bit counter with DATA_W-1, and enter SHIFT.
REQ-016 In SHIFT, sdo SHALL equal shift register MSB, sdo_en=1, and frame_start=1 only in the first SHIFT cycle.
REQ-017 In SHIFT, each edge SHALL shift the register left by one (zero fill) and decrement the counter.
REQ-018 At counter=0, the next edge SHALL go to PAR if configured, else to IDLE.
REQ-019 A frame SHALL occupy exactly DATA_W consecutive sdo_en cycles (DATA_W+1 with parity), starting in the cycle after the accept edge.
REQ-020 After each frame, the block SHALL spend at least one cycle in IDLE; minimum frame-to-frame period is DATA_W+1 cycles (DATA_W+2 with parity).
REQ-021 In IDLE, sdo and sdo_en SHALL be 0.
REQ-022 Changes on valid/data during SHIFT or PAR SHALL NOT affect the frame in flight.
REQ-023 A requester whose valid stays high while the other is served SHALL be granted at the next IDLE; no requester SHALL wait more than one frame.

Reset
REQ-024 While reset_n=0, the block SHALL force: state=IDLE, shift register=0, counter=0, grant_id=0, last_grant=1 (req0 wins first contest), sdo=0, sdo_en=0, frame_start=0, busy=0, both readies=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; no partial bits SHALL appear after release, and the first accept after release SHALL follow REQ-014 with last_grant=1.

Configuration
REQ-026 With macro SHIFT_TX_PARITY_EN defined, the block SHALL append one PAR cycle after the last data bit: sdo = even parity (XOR) of the accepted word, sdo_en=1, frame_start=0, then IDLE.
REQ-027 Without SHIFT_TX_PARITY_EN, the PAR state and parity logic SHALL be absent and frames SHALL be DATA_W bits.

Verification (DATA_W=8)
REQ-028 Single requester: req0_valid=1, data=8'hA5 in IDLE -> req0_ready=1 one cycle; next 8 cycles sdo=1,0,1,0,0,1,0,1, sdo_en=1, frame_start only on first, grant_id=0; then IDLE.
REQ-029 Contention: both valid from reset release, data0=8'h0F, data1=8'hF0 -> frames in order req0, req1, req0, ... with a single IDLE gap cycle between frames.
REQ-030 Data change mid-frame: accept 8'hC3, then change req0_data to 8'h00 during SHIFT -> sdo still 1,1,0,0,0,0,1,1.
REQ-031 Reset mid-frame: assert reset_n=0 at bit 4 of 8'hFF -> sdo, sdo_en and busy go 0 without waiting for a clock edge; after release, a new 8'h81 frame is sent complete and correct.
REQ-032 Parity build: 8'h07 -> 9 sdo_en cycles with last bit 1; 8'h03 -> last bit 0; frame period 10 cycles.
REQ-033 Back-to-back: req1 alone, valid held high -> ready pulses exactly every 9 cycles (10 with parity); busy low only in the gap cycle.

Source files
------------

// File: rtl/shift_tx_sched.sv
// rtl/shift_tx_sched.sv - two-requester round-robin parallel-to-serial frame scheduler
//
// Purpose:
//   Accepts a DATA_W-bit word from one of two valid/ready requesters and
//   shifts it out MSB first on sdo, one bit per clock. When both requesters
//   are offering a word, the one not served last is granted.
//
// Build option:
//   SHIFT_TX_PARITY_EN - when defined, each frame is followed by one extra
//   bit carrying the even parity (XOR) of the word.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req0_valid/data/ready   requester 0 handshake and word
//   req1_valid/data/ready   requester 1 handshake and word
//   sdo, sdo_en             serial data and qualifier
//   frame_start             high on the first bit of each frame
//   grant_id                requester whose frame is on sdo
//   busy                    high whenever a frame is in progress
module shift_tx_sched #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              sdo,
  output logic              sdo_en,
  output logic              frame_start,
  output logic              grant_id,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               first_q, first_d;
`ifdef SHIFT_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               pick;
  logic [DATA_W-1:0]  acc_word;

  // With both requesters offering, pick the one not served last; otherwise
  // pick whichever is valid. Readies are held low while reset is asserted.
  always_comb begin
    pick       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = reset_n && (state_q == IDLE) && req0_valid && !pick;
    req1_ready = reset_n && (state_q == IDLE) && req1_valid && pick;
    acc_word   = req1_ready ? req1_data : req0_data;
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_d      = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          shreg_d      = acc_word;
          grant_d      = req1_ready;
          last_grant_d = req1_ready;
          cnt_d        = CNT_W'(DATA_W - 1);
          first_d      = 1'b1;
          state_d      = SHIFT;
`ifdef SHIFT_TX_PARITY_EN
          par_d        = ^acc_word;
`endif
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        if (cnt_q == '0) begin
`ifdef SHIFT_TX_PARITY_EN
          state_d = PAR;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SHIFT_TX_PARITY_EN
      PAR: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      first_q      <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
`ifdef SHIFT_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  // Outputs decode from state only, so reset clears them without a clock edge.
  always_comb begin
    sdo         = 1'b0;
    sdo_en      = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      SHIFT: begin
        sdo         = shreg_q[DATA_W-1];
        sdo_en      = 1'b1;
        frame_start = first_q;
      end
`ifdef SHIFT_TX_PARITY_EN
      PAR: begin
        sdo    = par_q;
        sdo_en = 1'b1;
      end
`endif
      default: begin
        sdo = 1'b0;
      end
    endcase
    busy     = (state_q != IDLE);
    grant_id = grant_q;
  end

endmodule

// File: tb/tb_shift_tx_sched.sv
// tb/tb_shift_tx_sched.sv - directed self-checking bench for shift_tx_sched
module tb_shift_tx_sched;

  localparam int DATA_W = 8;
`ifdef SHIFT_TX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int PERIOD = FRAME_LEN + 1;

  logic              clk;
  logic              reset_n;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              sdo, sdo_en, frame_start, grant_id, busy;

  int n_checks;
  int n_errors;

  shift_tx_sched #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .sdo         (sdo),
    .sdo_en      (sdo_en),
    .frame_start (frame_start),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called in the first SHIFT cycle; returns in the cycle after the frame.
  task automatic expect_frame(input logic [DATA_W-1:0] w, input logic g);
    logic [DATA_W-1:0] ref_w;
    ref_w = w;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < DATA_W) chk($sformatf("sdo[%0d]", i), sdo, ref_w[DATA_W-1-i]);
      else            chk("sdo_par", sdo, ^ref_w);
      chk($sformatf("sdo_en[%0d]", i), sdo_en, 1'b1);
      chk($sformatf("frame_start[%0d]", i), frame_start, (i == 0));
      chk($sformatf("grant_id[%0d]", i), grant_id, g);
      chk($sformatf("rdy_busy[%0d]", i), {req1_ready, req0_ready, busy}, 3'b001);
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    tick();
    // Reset state: readies held low even with valids high.
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_out", {sdo, sdo_en, frame_start, busy, grant_id}, 5'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    do_reset();

    // Single requester, 8'hA5.
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    #1;
    chk("single_ready", {req1_ready, req0_ready}, 2'b01);
    chk("idle_sdo", {sdo, sdo_en, busy}, 3'b000);
    tick();
    req0_valid = 1'b0;
    expect_frame(8'hA5, 1'b0);
    chk("single_done", {busy, sdo_en, sdo}, 3'b000);

    // Contention from reset release.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h0F;
    req1_data  = 8'hF0;
    do_reset();
    chk("cont_first", {req1_ready, req0_ready}, 2'b01);
    tick();
    expect_frame(8'h0F, 1'b0);
    chk("cont_gap1", {busy, req1_ready, req0_ready}, 3'b010);
    tick();
    expect_frame(8'hF0, 1'b1);
    chk("cont_gap2", {busy, req1_ready, req0_ready}, 3'b001);
    tick();
    expect_frame(8'h0F, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Data change mid-frame.
    req0_valid = 1'b1;
    req0_data  = 8'hC3;
    #1;
    chk("chg_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    expect_frame(8'hC3, 1'b0);

    // Reset at bit 4 of 8'hFF; req0 was served last so without reset req1
    // would win the next contest.
    req0_valid = 1'b1;
    req0_data  = 8'hFF;
    #1;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_sdo_en", {sdo_en, sdo, busy}, 3'b111);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {sdo_en, sdo, busy}, 3'b000);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", {sdo_en, busy}, 2'b00);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h81;
    req1_data  = 8'h7E;
    #1;
    chk("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    expect_frame(8'h81, 1'b0);

    // Back-to-back requester 1 with valid held.
    req1_valid = 1'b1;
    req1_data  = 8'h5A;
    #1;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      chk($sformatf("b2b_ready[%0d]", c), req1_ready, (c % PERIOD) == 0);
      chk($sformatf("b2b_busy[%0d]", c), busy, (c % PERIOD) != 0);
      tick();
    end
    req1_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
